mem_access_stage: RTL and testbench

Memory-access stage between the EX/MEM pipeline register and MEM_WB. It runs loads and stores against the data memory over a req/ack handshake and stalls the upstream pipeline until each access completes. Stores get byte-lane alignment; loads get alignment plus sign or zero extension. Each instruction reaches MEM_WB exactly once: formatted load data for a memory operation, a plain pass-through for anything else.

---
 rtl/mem_access_stage_if.sv | 30 +++
 rtl/mem_access_stage.sv | 215 +++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the memory-access stage (master) and the data
// memory (slave). A request is held stable until ack is sampled high; read
// data is valid in the same cycle as ack.
//
//   dmem_req    master -> slave  request pending
//   dmem_we     master -> slave  1 = write, 0 = read
//   dmem_addr   master -> slave  word address (bits [1:0] always 0)
//   dmem_wdata  master -> slave  lane-replicated store data
//   dmem_be     master -> slave  byte enables
//   dmem_ack    slave -> master  access complete
//   dmem_rdata  slave -> master  read word, valid with ack
interface mem_access_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage between EX/MEM and MEM_WB.
// Runs loads and stores against the data memory over a req/ack bus and
// stalls the upstream pipeline until each access completes. Stores are
// lane-aligned with byte enables; loads are lane-selected and sign- or
// zero-extended. Non-memory instructions pass straight through.
//
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   in_valid           EX/MEM holds a real instruction
//   control_word_in    control word (load/store/size/unsigned bits)
//   PC_in, immediate_in, FU_result_in (byte address), store_data_in
//   stall_out          freeze EX/MEM and earlier stages
//   bus                data-memory bus (master side)
//   control_word_out   to MEM_WB, 0 = bubble
//   PC_out, immediate_out, FU_result_out, Mem_Data_out  to MEM_WB
//   misalign_err, bus_err  registered single-cycle error pulses
module mem_access_stage #(
  parameter int RD_BIT   = 3,
  parameter int WR_BIT   = 4,
  parameter int SIZE_LSB = 5,
  parameter int UNS_BIT  = 7,
  parameter int TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [34:0] control_word_in,
  input  logic [31:0] PC_in,
  input  logic [31:0] immediate_in,
  input  logic [31:0] FU_result_in,
  input  logic [31:0] store_data_in,
  output logic        stall_out,
  mem_access_stage_if.master bus,
  output logic [34:0] control_word_out,
  output logic [31:0] PC_out,
  output logic [31:0] immediate_out,
  output logic [31:0] FU_result_out,
  output logic [31:0] Mem_Data_out,
  output logic        misalign_err,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t state_q, state_d;

  // Holding registers for the instruction in flight.
  logic [34:0] cw_q;
  logic [31:0] pc_q, imm_q, fu_q, rdata_q;
  logic [7:0]  cnt_q, cnt_inc;

  // Input decode.
  logic        is_st, is_ld, mem_op, misaligned, issue, timeout_hit;
  logic [1:0]  size_in;
  logic [31:0] wdata_fmt;
  logic [3:0]  be_fmt;

  // Lane-select and extend a read word using the held byte offset and size.
  function automatic logic [31:0] load_fmt(input logic [31:0] w,
                                           input logic [1:0]  ofs,
                                           input logic [1:0]  sz,
                                           input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{ofs, 3'b000} +: 8];
    h = ofs[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   return uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   return uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  assign size_in = control_word_in[SIZE_LSB +: 2];
  assign is_st   = control_word_in[WR_BIT];
  assign is_ld   = control_word_in[RD_BIT];
  assign mem_op  = in_valid && (is_st || is_ld);
  // Size 11 is treated as a word, so any size with bit 1 set needs word alignment.
  assign misaligned = ((size_in == 2'b01) && FU_result_in[0]) ||
                      (size_in[1] && (FU_result_in[1:0] != 2'b00));
  assign issue   = (state_q == IDLE) && mem_op && !misaligned;
  assign cnt_inc = cnt_q + 8'd1;
  // Ack in the firing cycle takes priority over the timeout.
  assign timeout_hit = (state_q == ACCESS) && !bus.dmem_ack &&
                       (cnt_inc == TIMEOUT_CNT);

  // Store lane formatting; loads read the full word.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    wdata_fmt = '0;
    be_fmt    = 4'hF;
    if (is_st) begin
      case (size_in)
        2'b00: begin
          wdata_fmt = {4{store_data_in[7:0]}};
          be_fmt    = 4'b0001 << FU_result_in[1:0];
        end
        2'b01: begin
          wdata_fmt = {2{store_data_in[15:0]}};
          be_fmt    = 4'b0011 << {FU_result_in[1], 1'b0};
        end
        default: wdata_fmt = store_data_in;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (issue) state_d = ACCESS;
      ACCESS:  if (bus.dmem_ack || timeout_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic toward the pipeline.
  always_comb begin
    stall_out        = 1'b0;
    control_word_out = '0;
    PC_out           = PC_in;
    immediate_out    = immediate_in;
    FU_result_out    = FU_result_in;
    Mem_Data_out     = '0;
    case (state_q)
      IDLE: begin
        stall_out = issue;
        // Memory ops (aligned or not) leave as a bubble from IDLE.
        if (in_valid && !mem_op) control_word_out = control_word_in;
      end
      ACCESS: begin
        stall_out     = 1'b1;
        PC_out        = pc_q;
        immediate_out = imm_q;
        FU_result_out = fu_q;
      end
      DONE: begin
        control_word_out = cw_q;
        PC_out           = pc_q;
        immediate_out    = imm_q;
        FU_result_out    = fu_q;
        Mem_Data_out     = rdata_q;
      end
      default: ;
    endcase
    // No instruction may reach MEM_WB while reset is held.
    if (!rst) control_word_out = '0;
  end

  // Holding registers, bus registers, timeout counter and error pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cw_q           <= '0;
      pc_q           <= '0;
      imm_q          <= '0;
      fu_q           <= '0;
      rdata_q        <= '0;
      cnt_q          <= '0;
      bus.dmem_req   <= 1'b0;
      bus.dmem_we    <= 1'b0;
      bus.dmem_addr  <= '0;
      bus.dmem_wdata <= '0;
      bus.dmem_be    <= '0;
      misalign_err   <= 1'b0;
      bus_err        <= 1'b0;
    end else begin
      misalign_err <= (state_q == IDLE) && mem_op && misaligned;
      bus_err      <= timeout_hit;
      case (state_q)
        IDLE: begin
          if (issue) begin
            cw_q           <= control_word_in;
            pc_q           <= PC_in;
            imm_q          <= immediate_in;
            fu_q           <= FU_result_in;
            cnt_q          <= '0;
            bus.dmem_req   <= 1'b1;
            bus.dmem_we    <= is_st;
            bus.dmem_addr  <= {FU_result_in[31:2], 2'b00};
            bus.dmem_wdata <= wdata_fmt;
            bus.dmem_be    <= be_fmt;
          end
        end
        ACCESS: begin
          cnt_q <= cnt_inc;
          if (bus.dmem_ack) begin
            bus.dmem_req <= 1'b0;
            rdata_q      <= cw_q[WR_BIT] ? '0 :
                            load_fmt(bus.dmem_rdata, fu_q[1:0],
                                     cw_q[SIZE_LSB +: 2], cw_q[UNS_BIT]);
          end else if (timeout_hit) begin
            // Abandoned access leaves MEM_WB as a bubble.
            bus.dmem_req <= 1'b0;
            rdata_q      <= '0;
            cw_q         <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage (TIMEOUT = 4).
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [34:0] control_word_in;
  logic [31:0] PC_in, immediate_in, FU_result_in, store_data_in;
  logic        stall_out;
  logic [34:0] control_word_out;
  logic [31:0] PC_out, immediate_out, FU_result_out, Mem_Data_out;
  logic        misalign_err, bus_err;

  mem_access_stage_if bus ();

  mem_access_stage #(.TIMEOUT(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .control_word_in  (control_word_in),
    .PC_in            (PC_in),
    .immediate_in     (immediate_in),
    .FU_result_in     (FU_result_in),
    .store_data_in    (store_data_in),
    .stall_out        (stall_out),
    .bus              (bus),
    .control_word_out (control_word_out),
    .PC_out           (PC_out),
    .immediate_out    (immediate_out),
    .FU_result_out    (FU_result_out),
    .Mem_Data_out     (Mem_Data_out),
    .misalign_err     (misalign_err),
    .bus_err          (bus_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One memory op: issue, k ACCESS cycles with ack in the k-th, then DONE.
  task automatic mem_op(input string tag, input logic [34:0] cw, input logic [31:0] addr,
                        input logic [31:0] sdata, input int k, input logic [31:0] rdata,
                        input logic [31:0] exp_addr, input logic [3:0] exp_be,
                        input logic exp_we, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_mem);
    @(negedge clk);
    in_valid = 1'b1; control_word_in = cw; FU_result_in = addr;
    store_data_in = sdata; PC_in = 32'h0000_4000; immediate_in = 32'h77;
    #1;
    check({tag, "_issue_stall"}, stall_out, 1);
    check({tag, "_issue_bubble"}, control_word_out, 0);
    for (int i = 1; i <= k; i++) begin
      @(negedge clk);
      bus.dmem_ack   = (i == k);
      bus.dmem_rdata = (i == k) ? rdata : 32'hDEAD_BEEF;
      #1;
      check({tag, "_req"}, bus.dmem_req, 1);
      check({tag, "_addr"}, bus.dmem_addr, exp_addr);
      check({tag, "_be"}, bus.dmem_be, exp_be);
      check({tag, "_we"}, bus.dmem_we, exp_we);
      if (exp_we) check({tag, "_wdata"}, bus.dmem_wdata, exp_wdata);
      check({tag, "_acc_stall"}, stall_out, 1);
      check({tag, "_acc_bubble"}, control_word_out, 0);
    end
    // DONE: upstream inputs changed to show the held copy is presented.
    @(negedge clk);
    bus.dmem_ack = 1'b0; in_valid = 1'b0; PC_in = 32'h0;
    #1;
    check({tag, "_done_stall"}, stall_out, 0);
    check({tag, "_done_cw"}, control_word_out, cw);
    check({tag, "_done_pc"}, PC_out, 32'h0000_4000);
    check({tag, "_done_fu"}, FU_result_out, addr);
    check({tag, "_done_data"}, Mem_Data_out, exp_mem);
    check({tag, "_done_req"}, bus.dmem_req, 0);
    @(negedge clk);
    #1;
    check({tag, "_idle_cw"}, control_word_out, 0);
    check({tag, "_idle_stall"}, stall_out, 0);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; control_word_in = '0; PC_in = '0;
    immediate_in = '0; FU_result_in = '0; store_data_in = '0;
    bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;

    // Reset state; control word forced to 0 even with a valid ALU op present.
    @(negedge clk);
    in_valid = 1'b1; control_word_in = 35'h1;
    #1;
    check("rst_cw_forced", control_word_out, 0);
    check("rst_req", bus.dmem_req, 0);
    check("rst_be", bus.dmem_be, 0);
    check("rst_addr", bus.dmem_addr, 0);
    check("rst_misalign", misalign_err, 0);
    check("rst_buserr", bus_err, 0);

    // ALU op pass-through; a stray ack in IDLE is ignored.
    @(negedge clk);
    rst = 1'b1; FU_result_in = 32'h10; PC_in = 32'h100; immediate_in = 32'h5;
    bus.dmem_ack = 1'b1;
    #1;
    check("alu_cw", control_word_out, 35'h1);
    check("alu_fu", FU_result_out, 32'h10);
    check("alu_pc", PC_out, 32'h100);
    check("alu_imm", immediate_out, 32'h5);
    check("alu_stall", stall_out, 0);
    check("alu_data", Mem_Data_out, 0);
    check("alu_req", bus.dmem_req, 0);
    @(negedge clk);
    bus.dmem_ack = 1'b0; control_word_in = 35'h2;
    #1;
    check("alu2_cw", control_word_out, 35'h2);
    check("alu2_stall", stall_out, 0);
    check("alu2_req", bus.dmem_req, 0);

    // Loads and stores: cw bits RD=3, WR=4, size[6:5], UNS=7.
    mem_op("lb_s",  35'h08, 32'h1003, 32'h0, 2, 32'h8000_0000,
           32'h1000, 4'hF, 1'b0, 32'h0, 32'hFFFF_FF80);
    mem_op("lb_u",  35'h88, 32'h1003, 32'h0, 2, 32'h8000_0000,
           32'h1000, 4'hF, 1'b0, 32'h0, 32'h0000_0080);
    mem_op("sh",    35'h30, 32'h2002, 32'h0000_ABCD, 1, 32'h0,
           32'h2000, 4'b1100, 1'b1, 32'hABCD_ABCD, 32'h0);
    mem_op("lh_s",  35'h28, 32'h1002, 32'h0, 1, 32'h8001_1234,
           32'h1000, 4'hF, 1'b0, 32'h0, 32'hFFFF_8001);
    mem_op("sb",    35'h10, 32'h3001, 32'h1234_5678, 1, 32'h0,
           32'h3000, 4'b0010, 1'b1, 32'h7878_7878, 32'h0);
    mem_op("lw",    35'h48, 32'h4000, 32'h0, 3, 32'hCAFE_F00D,
           32'h4000, 4'hF, 1'b0, 32'h0, 32'hCAFE_F00D);

    // Misaligned word load: no request, bubble, one-cycle error pulse.
    @(negedge clk);
    in_valid = 1'b1; control_word_in = 35'h48; FU_result_in = 32'h2001;
    #1;
    check("mis_req", bus.dmem_req, 0);
    check("mis_stall", stall_out, 0);
    check("mis_bubble", control_word_out, 0);
    check("mis_err_early", misalign_err, 0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("mis_err_pulse", misalign_err, 1);
    check("mis_req2", bus.dmem_req, 0);
    @(negedge clk);
    #1;
    check("mis_err_clear", misalign_err, 0);

    // Timeout: no ack for 4 ACCESS cycles.
    @(negedge clk);
    in_valid = 1'b1; control_word_in = 35'h48; FU_result_in = 32'h5000;
    #1;
    check("to_issue_stall", stall_out, 1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      #1;
      check("to_req", bus.dmem_req, 1);
      check("to_stall", stall_out, 1);
      check("to_no_err", bus_err, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("to_req_drop", bus.dmem_req, 0);
    check("to_buserr", bus_err, 1);
    check("to_bubble", control_word_out, 0);
    check("to_stall_done", stall_out, 0);
    check("to_data", Mem_Data_out, 0);
    @(negedge clk);
    #1;
    check("to_buserr_clear", bus_err, 0);

    // Reset during ACCESS drops the request asynchronously.
    @(negedge clk);
    in_valid = 1'b1; control_word_in = 35'h48; FU_result_in = 32'h6000;
    #1;
    check("ra_issue_stall", stall_out, 1);
    @(negedge clk);
    #1;
    check("ra_req", bus.dmem_req, 1);
    #2;
    rst = 1'b0;
    #1;
    check("ra_req_async", bus.dmem_req, 0);
    check("ra_cw", control_word_out, 0);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    #1;
    check("ra_post_req", bus.dmem_req, 0);
    check("ra_post_stall", stall_out, 0);
    @(negedge clk);
    in_valid = 1'b1; control_word_in = 35'h1;
    #1;
    check("ra_idle_pass", control_word_out, 35'h1);
    mem_op("ra_lw", 35'h48, 32'h6000, 32'h0, 1, 32'h1234_5678,
           32'h6000, 4'hF, 1'b0, 32'h0, 32'h1234_5678);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
